// File: rtl/digitalclock_pkg.sv
// Shared mode codes and field limits for the digital clock.
// The mode FSM and the timekeeper both import this so the codes stay in step.
package digitalclock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  localparam int unsigned MAX_SEC = 59;
  localparam int unsigned MAX_MIN = 59;
  localparam int unsigned MAX_HR  = 23;

  // Increment a time field, wrapping to zero after its maximum value.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? '0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/digitalclock_timekeeper_if.sv
// Mode/adjust inputs and time/visibility outputs of the timekeeper.
// state_enum stays a raw 2-bit code because 2'b11 is a legal input (acts as RUN).
interface digitalclock_timekeeper_if;
  import digitalclock_pkg::*;

  logic [1:0] state_enum;
  logic       inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic       hours_vis;
  logic       minutes_vis;

  modport master (
    output state_enum, inc,
    input  hours, minutes, seconds, sec_tick, hours_vis, minutes_vis
  );

  modport slave (
    input  state_enum, inc,
    output hours, minutes, seconds, sec_tick, hours_vis, minutes_vis
  );

endinterface

// File: rtl/digitalclock_prescaler.sv
// Free-running seconds prescaler: one-cycle tick per CLK_DIV cycles and a
// 50 % duty blink phase. Never held or cleared outside reset.
module digitalclock_prescaler #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic phase
);

  localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(CLK_DIV / 2);

  logic [W-1:0] r_cnt;
  logic         r_tick;
  logic         r_phase;

  // Count 0..CLK_DIV-1; tick and phase are registered decodes of the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
      r_tick  <= (r_cnt == LAST);
      r_phase <= (r_cnt >= HALF);
    end
  end

  assign tick  = r_tick;
  assign phase = r_phase;

endmodule

// File: rtl/digitalclock_timekeeper.sv
// Time-of-day keeper (hh:mm:ss, 24 h) driven by the clock's mode code.
// Counts in RUN, edits hours/minutes in SET_HR/SET_MIN, blinks the edited field.
module digitalclock_timekeeper
  import digitalclock_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  digitalclock_timekeeper_if.slave   bus
);

  logic       w_tick;
  logic       w_phase;
  logic [4:0] r_hours;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_hours_vis;
  logic       r_min_vis;
  logic [4:0] w_hours_nxt;
  logic [5:0] w_min_nxt;
  logic [5:0] w_sec_nxt;

  digitalclock_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .tick  (w_tick),
    .phase (w_phase)
  );

  // Mode-decoded next time; in SET modes inc wins and ticks are dropped,
  // in RUN (and the unused 2'b11 code) ticks count and inc is dropped.
  always_comb begin
    w_hours_nxt = r_hours;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    case (bus.state_enum)
      SET_HR: begin
        if (bus.inc) begin
          w_hours_nxt = 5'(inc_wrap({1'b0, r_hours}, 6'(MAX_HR)));
        end
      end
      SET_MIN: begin
        if (bus.inc) begin
          w_min_nxt = inc_wrap(r_min, 6'(MAX_MIN));
          w_sec_nxt = '0;
        end
      end
      default: begin
        if (w_tick) begin
          w_sec_nxt = inc_wrap(r_sec, 6'(MAX_SEC));
          if (r_sec == 6'(MAX_SEC)) begin
            w_min_nxt = inc_wrap(r_min, 6'(MAX_MIN));
            if (r_min == 6'(MAX_MIN)) begin
              w_hours_nxt = 5'(inc_wrap({1'b0, r_hours}, 6'(MAX_HR)));
            end
          end
        end
      end
    endcase
  end

  // Time registers and blink-gated visibility of the field being edited.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hours     <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_hours_vis <= 1'b1;
      r_min_vis   <= 1'b1;
    end else begin
      r_hours     <= w_hours_nxt;
      r_min       <= w_min_nxt;
      r_sec       <= w_sec_nxt;
      r_hours_vis <= !((bus.state_enum == SET_HR)  && w_phase);
      r_min_vis   <= !((bus.state_enum == SET_MIN) && w_phase);
    end
  end

  assign bus.hours       = r_hours;
  assign bus.minutes     = r_min;
  assign bus.seconds     = r_sec;
  assign bus.sec_tick    = w_tick;
  assign bus.hours_vis   = r_hours_vis;
  assign bus.minutes_vis = r_min_vis;

endmodule
